// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and the
// default operand width.
package serial_subtractor_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_t;

endpackage

// File: rtl/serial_subtractor_fs.sv
// One-bit full subtractor: d = a - b - bin, with the borrow out of this bit.
module fs (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: captures a and b on start, then produces
// a - b one bit per cycle LSB first, pulsing done when the result is complete.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    // One extra bit of range so the terminal count never wraps (also >= 1 bit at WIDTH=1).
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] diff_shift;
    logic [CW-1:0]    cnt_q;
    logic             borrow_q;
    logic             busy_q;
    logic             done_q;
    logic             bit_d;
    logic             bit_borrow;

    fs u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (borrow_q),
        .d    (bit_d),
        .bout (bit_borrow)
    );

    // New result bit enters at the MSB so the LSB-first stream ends up in place.
    always_comb begin
        diff_shift            = diff_q >> 1;
        diff_shift[WIDTH-1]   = bit_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StShift;
                    end
                end
                StShift: begin
                    diff_q   <= diff_shift;
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    borrow_q <= bit_borrow;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: directed cases plus random operations on WIDTH=8 and WIDTH=1 instances.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start8, start1;
    logic [7:0] a8, b8, diff8;
    logic [0:0] a1, b1, diff1;
    logic       busy8, done8, bout8;
    logic       busy1, done1, bout1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rstn  (rstn),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .diff  (diff8),
        .bout  (bout8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rstn  (rstn),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .busy  (busy1),
        .done  (done1),
        .diff  (diff1),
        .bout  (bout1)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel1, input logic s, input logic [7:0] av, input logic [7:0] bv);
        if (sel1) begin
            start1 = s;
            a1     = av[0:0];
            b1     = bv[0:0];
        end else begin
            start8 = s;
            a8     = av;
            b8     = bv;
        end
    endtask

    // Full operation: start on one cycle, check done/busy each cycle, then result and hold.
    task automatic run_op(input bit sel1, input logic [7:0] av, input logic [7:0] bv,
                          input bit hold, input string tag);
        int         w;
        logic [7:0] mask, ea, eb, ed;
        logic [8:0] wide;
        logic       eborrow;
        w       = sel1 ? 1 : 8;
        mask    = sel1 ? 8'h01 : 8'hFF;
        ea      = av & mask;
        eb      = bv & mask;
        wide    = {1'b0, ea} - {1'b0, eb};
        ed      = wide[7:0] & mask;
        eborrow = ea < eb;

        @(negedge clk);
        drive(sel1, 1'b1, av, bv);
        @(posedge clk);
        for (int k = 1; k <= w + 1; k++) begin
            @(negedge clk);
            if (hold) drive(sel1, 1'b1, 8'h55, 8'h00);
            else      drive(sel1, 1'b0, 8'($urandom), 8'($urandom));
            chk({tag, ".done"}, {7'd0, sel1 ? done1 : done8}, {7'd0, k == w + 1});
            chk({tag, ".busy"}, {7'd0, sel1 ? busy1 : busy8}, 8'd1);
        end
        chk({tag, ".diff"}, sel1 ? {7'd0, diff1} : diff8, ed);
        chk({tag, ".bout"}, {7'd0, sel1 ? bout1 : bout8}, {7'd0, eborrow});
        @(negedge clk);
        drive(sel1, 1'b0, 8'($urandom), 8'($urandom));
        chk({tag, ".idle_busy"}, {7'd0, sel1 ? busy1 : busy8}, 8'd0);
        chk({tag, ".idle_done"}, {7'd0, sel1 ? done1 : done8}, 8'd0);
        @(negedge clk);
        chk({tag, ".hold_busy"}, {7'd0, sel1 ? busy1 : busy8}, 8'd0);
        chk({tag, ".hold_diff"}, sel1 ? {7'd0, diff1} : diff8, ed);
        chk({tag, ".hold_bout"}, {7'd0, sel1 ? bout1 : bout8}, {7'd0, eborrow});
    endtask

    initial begin
        rstn = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        @(negedge clk);
        chk("rst.busy8", {7'd0, busy8}, 8'd0);
        chk("rst.done8", {7'd0, done8}, 8'd0);
        chk("rst.diff8", diff8, 8'd0);
        chk("rst.bout8", {7'd0, bout8}, 8'd0);
        chk("rst.busy1", {7'd0, busy1}, 8'd0);
        chk("rst.diff1", {7'd0, diff1}, 8'd0);
        rstn = 1'b1;

        run_op(1'b0, 8'h05, 8'h03, 1'b0, "d05_03");
        run_op(1'b0, 8'h03, 8'h05, 1'b0, "d03_05");
        run_op(1'b0, 8'h00, 8'h00, 1'b0, "d00_00");
        run_op(1'b0, 8'hFF, 8'h01, 1'b0, "dFF_01");
        run_op(1'b0, 8'h00, 8'hFF, 1'b0, "d00_FF");
        // start stays high with new operands through SHIFT and DONE
        run_op(1'b0, 8'h10, 8'h01, 1'b1, "dhold");

        // Reset in the middle of SHIFT
        @(negedge clk);
        drive(1'b0, 1'b1, 8'h12, 8'h34);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h12, 8'h34);
        @(negedge clk);
        chk("mid.busy", {7'd0, busy8}, 8'd1);
        rstn = 1'b0;
        #1;
        chk("arst.busy", {7'd0, busy8}, 8'd0);
        chk("arst.done", {7'd0, done8}, 8'd0);
        chk("arst.diff", diff8, 8'd0);
        chk("arst.bout", {7'd0, bout8}, 8'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("arst.nodone", {7'd0, done8}, 8'd0);
            if (k == 2) rstn = 1'b1;
        end
        run_op(1'b0, 8'h80, 8'h7F, 1'b0, "d80_7F");

        for (int i = 0; i < 500; i++) run_op(1'b0, 8'($urandom), 8'($urandom), 1'b0, "rnd8");
        for (int i = 0; i < 500; i++) run_op(1'b1, 8'($urandom), 8'($urandom), 1'b0, "rnd1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
